// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop sync, per-button debounce FSM,
// registered level, press/release pulses, lowest-index press and any-held flag.
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int CNT_W           = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_first,
  output logic             btn_any
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } state_e;

  logic [N_BTN-1:0] s1_q, s2_q;
  logic [N_BTN-1:0] level_d, press_d;
  logic [N_BTN-1:0] first_d, first_q;
  logic             any_q;

  // Two-flop synchroniser for the asynchronous raw inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             prs_q, prs_d;
    logic             rls_q, rls_d;
    logic             s2;

    assign s2 = s2_q[g];

    // Debounce next-state: qualify each level change over CNT_MAX+1 samples
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      prs_d = 1'b0;
      rls_d = 1'b0;
      case (st_q)
        RELEASED: begin
          if (s2) begin
            st_d  = ARM_PRESS;
            cnt_d = '0;
          end
        end
        ARM_PRESS: begin
          if (!s2) begin
            st_d  = RELEASED;
            cnt_d = '0;
          end else if (cnt_q == CNT_MAX) begin
            st_d  = PRESSED;
            cnt_d = '0;
            prs_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!s2) begin
            st_d  = ARM_RELEASE;
            cnt_d = '0;
          end
        end
        ARM_RELEASE: begin
          if (s2) begin
            st_d  = PRESSED;
            cnt_d = '0;
          end else if (cnt_q == CNT_MAX) begin
            st_d  = RELEASED;
            cnt_d = '0;
            rls_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          st_d  = RELEASED;
          cnt_d = '0;
        end
      endcase
      lvl_d = (st_d == PRESSED) || (st_d == ARM_RELEASE);
    end

    // Per-button state, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= RELEASED;
        cnt_q <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rls_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
        prs_q <= prs_d;
        rls_q <= rls_d;
      end
    end

    assign level_d[g]     = lvl_d;
    assign press_d[g]     = prs_d;
    assign btn_level[g]   = lvl_q;
    assign btn_press[g]   = prs_q;
    assign btn_release[g] = rls_q;
  end

  // Isolate the lowest set bit of the next press vector
  always_comb begin
    first_d = press_d & (~press_d + N_BTN'(1));
  end

  // Cross-button flags registered alongside the per-button outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= '0;
      any_q   <= 1'b0;
    end else begin
      first_q <= first_d;
      any_q   <= |level_d;
    end
  end

  assign btn_first = first_q;
  assign btn_any   = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change and outputs are sampled on the falling edge.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_first;
  logic       btn_any;

  int ck;
  int er;

  button_conditioner #(
    .N_BTN(4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_first(btn_first),
    .btn_any(btn_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n   = 1'b0;
    btn_raw = 4'b0000;
    repeat (3) @(negedge clk);
    ck++;
    if (btn_level !== 4'b0000) begin
      er++;
      $display("FAIL reset_level got %b exp 0000", btn_level);
    end
    ck++;
    if (btn_press !== 4'b0000 || btn_release !== 4'b0000) begin
      er++;
      $display("FAIL reset_pulses got %b/%b exp 0000/0000",
               btn_press, btn_release);
    end
    ck++;
    if (btn_first !== 4'b0000 || btn_any !== 1'b0) begin
      er++;
      $display("FAIL reset_first_any got %b/%b exp 0000/0",
               btn_first, btn_any);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Raw changes now; the next posedge is edge 0.
  task automatic test_single_press();
    btn_raw = 4'b0001;
    for (int e = 0; e <= 5; e++) begin
      @(negedge clk);
      ck++;
      if (btn_press !== 4'b0000 || btn_level !== 4'b0000) begin
        er++;
        $display("FAIL press_early e%0d got %b/%b exp 0000/0000",
                 e, btn_press, btn_level);
      end
    end
    @(negedge clk);
    ck++;
    if (btn_press !== 4'b0001 || btn_level !== 4'b0001) begin
      er++;
      $display("FAIL press_e6 got %b/%b exp 0001/0001",
               btn_press, btn_level);
    end
    ck++;
    if (btn_first !== 4'b0001 || btn_any !== 1'b1) begin
      er++;
      $display("FAIL press_first_any got %b/%b exp 0001/1",
               btn_first, btn_any);
    end
    @(negedge clk);
    ck++;
    if (btn_press !== 4'b0000 || btn_level !== 4'b0001) begin
      er++;
      $display("FAIL press_e7 got %b/%b exp 0000/0001",
               btn_press, btn_level);
    end
  endtask

  task automatic test_release();
    btn_raw = 4'b0000;
    for (int e = 0; e <= 5; e++) begin
      @(negedge clk);
      ck++;
      if (btn_release !== 4'b0000 || btn_level !== 4'b0001) begin
        er++;
        $display("FAIL rel_early e%0d got %b/%b exp 0000/0001",
                 e, btn_release, btn_level);
      end
    end
    @(negedge clk);
    ck++;
    if (btn_release !== 4'b0001 || btn_level !== 4'b0000
        || btn_any !== 1'b0) begin
      er++;
      $display("FAIL rel_e6 got %b/%b/%b exp 0001/0000/0",
               btn_release, btn_level, btn_any);
    end
    @(negedge clk);
    ck++;
    if (btn_release !== 4'b0000) begin
      er++;
      $display("FAIL rel_e7 got %b exp 0000", btn_release);
    end
  endtask

  // High 3 cycles, low 2, then high: final rise sampled at edge 5.
  task automatic test_bounce();
    btn_raw = 4'b0100;
    for (int e = 0; e <= 10; e++) begin
      @(negedge clk);
      if (e == 2) btn_raw = 4'b0000;
      if (e == 4) btn_raw = 4'b0100;
      ck++;
      if (btn_press !== 4'b0000 || btn_level !== 4'b0000) begin
        er++;
        $display("FAIL bounce_quiet e%0d got %b/%b exp 0000/0000",
                 e, btn_press, btn_level);
      end
    end
    @(negedge clk);
    ck++;
    if (btn_press !== 4'b0100 || btn_level !== 4'b0100) begin
      er++;
      $display("FAIL bounce_press got %b/%b exp 0100/0100",
               btn_press, btn_level);
    end
    @(negedge clk);
    ck++;
    if (btn_press !== 4'b0000) begin
      er++;
      $display("FAIL bounce_single got %b exp 0000", btn_press);
    end
    btn_raw = 4'b0000;
    repeat (8) @(negedge clk);
    ck++;
    if (btn_level !== 4'b0000) begin
      er++;
      $display("FAIL bounce_cleanup got %b exp 0000", btn_level);
    end
  endtask

  task automatic test_simultaneous();
    btn_raw = 4'b1010;
    repeat (7) @(negedge clk);
    ck++;
    if (btn_press !== 4'b1010 || btn_first !== 4'b0010) begin
      er++;
      $display("FAIL simul_press got %b/%b exp 1010/0010",
               btn_press, btn_first);
    end
    @(negedge clk);
    ck++;
    if (btn_press !== 4'b0000 || btn_first !== 4'b0000) begin
      er++;
      $display("FAIL simul_drop got %b/%b exp 0000/0000",
               btn_press, btn_first);
    end
    repeat (3) @(negedge clk);
    ck++;
    if (btn_level !== 4'b1010 || btn_any !== 1'b1) begin
      er++;
      $display("FAIL simul_level got %b/%b exp 1010/1",
               btn_level, btn_any);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    ck++;
    if (btn_level !== 4'b0000 || btn_press !== 4'b0000
        || btn_release !== 4'b0000 || btn_first !== 4'b0000
        || btn_any !== 1'b0) begin
      er++;
      $display("FAIL rstmid_clear got %b/%b/%b/%b/%b exp all 0",
               btn_level, btn_press, btn_release, btn_first, btn_any);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      @(negedge clk);
      ck++;
      if (btn_press !== 4'b0000 || btn_release !== 4'b0000) begin
        er++;
        $display("FAIL rstmid_quiet e%0d got %b/%b exp 0000/0000",
                 e, btn_press, btn_release);
      end
    end
    @(negedge clk);
    ck++;
    if (btn_press !== 4'b1010 || btn_first !== 4'b0010) begin
      er++;
      $display("FAIL rstmid_press got %b/%b exp 1010/0010",
               btn_press, btn_first);
    end
    @(negedge clk);
  endtask

  task automatic test_release_glitch();
    btn_raw = 4'b1000;
    for (int e = 0; e <= 11; e++) begin
      @(negedge clk);
      if (e == 1) btn_raw = 4'b1010;
      ck++;
      if (btn_level !== 4'b1010 || btn_release !== 4'b0000) begin
        er++;
        $display("FAIL glitch e%0d got %b/%b exp 1010/0000",
                 e, btn_level, btn_release);
      end
    end
  endtask

  initial begin
    ck = 0;
    er = 0;
    rst_n = 1'b0;
    btn_raw = 4'b0000;
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_release_glitch();
    $display("CHECKS %0d ERRORS %0d", ck, er);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the four raw player push-buttons before they reach the reaction-game FSM and the other game modes. Each input is synchronised into the `clk` domain, debounced by a per-button state machine, and presented both as a clean level and as single-cycle press/release pulses. The block sits directly upstream of the reaction game: its `btn_level` bits drive that game's `btn1`..`btn4` inputs, and its pulses feed any logic that needs edge events.

## Interface

- `N_BTN`, default 4: number of buttons; bit i corresponds to player button i+1.
- `DEBOUNCE_CYCLES`, default 250_000: consecutive stable synchronised samples required to accept a level change; legal range ≥ 2.
- `CNT_W`, default 18: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.
- `clk`  in  1: system clock; single clock domain.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `btn_raw`  in  N_BTN: raw, asynchronous, bouncing button inputs; 1 = pressed.
- `btn_level`  out  N_BTN: debounced level, registered.
- `btn_press`  out  N_BTN: one-cycle pulse on each accepted 0→1 transition.
- `btn_release`  out  N_BTN: one-cycle pulse on each accepted 1→0 transition.
- `btn_first`  out  N_BTN: one-hot copy of the lowest-index set bit of `btn_press`; all zero when `btn_press` is zero.
- `btn_any`  out  1: OR of `btn_level`, registered.

## Operation

- **Synchroniser.** Each bit passes through two flops, `s1` and `s2`, both reset to 0. The FSM sees only `s2`.
- **Per-button FSM.** One instance per bit, each with its own counter. States:
  - RELEASED: if `s2`=1, go to ARM_PRESS with cnt=0.
  - ARM_PRESS:
    - if `s2`=0, return to RELEASED with cnt=0 (glitch rejected, no pulse);
    - else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED;
    - else cnt+1.
  - PRESSED: if `s2`=0, go to ARM_RELEASE with cnt=0.
  - ARM_RELEASE: mirror of ARM_PRESS with polarity inverted. Exits to RELEASED on completion, or back to PRESSED if `s2` returns to 1.
  - Illegal state encoding: recover to RELEASED with cnt=0 and outputs 0.
- **Outputs.** All outputs are registered and updated on the edge that performs the state transition.
  - `btn_level`=1 in PRESSED and ARM_RELEASE.
  - `btn_press`=1 for exactly the one cycle after entering PRESSED from ARM_PRESS.
  - `btn_release`=1 for exactly the one cycle after entering RELEASED from ARM_RELEASE.
- **Multiple buttons.**
  - Instances are fully independent.
  - Simultaneous presses produce multiple `btn_press` bits in the same cycle.
  - `btn_first` selects the lowest index, e.g. press on bits 1 and 3 gives `btn_first`=4'b0010.
- **Counter width.** The counter never wraps: it saturates at DEBOUNCE_CYCLES-1 because the FSM leaves the ARM state at that value.

## Timing

- Reset values (while `rst_n`=0): all sync flops, states=RELEASED, counters=0, `btn_level`=0, `btn_press`=0, `btn_release`=0, `btn_first`=0, `btn_any`=0.
- Press latency. Let edge 0 be the first rising edge that samples `btn_raw[i]`=1, with the input held steady after it.
  - `s2`=1 after edge 1.
  - ARM_PRESS is entered at edge 2.
  - PRESSED is entered at edge DEBOUNCE_CYCLES+2.
  - `btn_level` and `btn_press` go high after that edge; `btn_press` drops after the next edge.
- Release latency is identical: DEBOUNCE_CYCLES+2 edges.
- A bounce during ARM restarts qualification from the next stable sample. No partial credit is kept.
- Reset mid-operation: all state is cleared immediately, with no pulse emitted. A button still held after `rst_n` deasserts is re-qualified and produces a fresh `btn_press` DEBOUNCE_CYCLES+2 edges after reset release (edge 0 = first edge with `rst_n`=1).
- No input-to-output combinational paths.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

- **Single clean press.** Hold `btn_raw`=4'b0001 from edge 0.
  - `btn_level[0]`=1 and `btn_press`=4'b0001 after edge 6.
  - `btn_press`=0 after edge 7.
  - `btn_any`=1.
- **Bounce rejection.** Pulse `btn_raw[2]` high for 3 cycles, low for 2, then hold high.
  - No output activity during the bounce.
  - A single `btn_press[2]` pulse appears exactly 6 edges after the final rise is first sampled.
- **Release.** From a pressed state, drop `btn_raw[0]`.
  - `btn_release`=4'b0001 for one cycle, 6 edges after the first low sample.
  - `btn_level[0]`=0 and `btn_any`=0 at the same time.
- **Simultaneous press.** Raise bits 1 and 3 on the same edge.
  - `btn_press`=4'b1010 and `btn_first`=4'b0010 for one cycle.
  - `btn_level`=4'b1010 thereafter.
- **Reset mid-press.** Assert `rst_n`=0 while `btn_level[3]`=1 and `btn_raw[3]` is held.
  - All outputs go to 0 immediately.
  - After release, `btn_press[3]` pulses 6 edges after the first edge with `rst_n`=1.
- **Release glitch.** While pressed, pulse `btn_raw[1]` low for 2 cycles.
  - `btn_level[1]` stays 1.
  - No `btn_release` pulse.
